frac_feeder: RTL and testbench
==============================

FRAC_FEEDER -- requirements
Module: frac_feeder

Interface
REQ-001 Parameter: RSLT_LAT, 1, number of cycles from the last stream beat to the result sample; legal range 1..4.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 ld_valid  in  1  row write strobe.
REQ-005 ld_sel  in  1  0 = current block, 1 = original block.
REQ-006 ld_row  in  3  row index 0..7.
REQ-007 ld_data  in  64  8 pixels x 8 bits; pixel 0 in [7:0].
REQ-008 ld_ready  out  1  write accepted when high.
REQ-009 start  in  1  single-cycle request to stream the stored block pair.
REQ-010 busy  out  1  high in any state other than IDLE.
REQ-011 fs_ready  out  1  beat strobe to the fractional search stage.
REQ-012 fs_cur_pix  out  64  current-block row for this beat.
REQ-013 fs_org_pix  out  48  original-block row bits [55:8] for this beat.
REQ-014 fs_sad / fs_mvx / fs_mvy  in  12/3/3  result returned by the search stage.
REQ-015 res_valid  out  1  result available; held until acknowledged.
REQ-016 res_sad / res_mvx / res_mvy  out  12/3/3  captured result.
REQ-017 res_ack  in  1  consumer acknowledge.

Function
REQ-018 States SHALL be IDLE, STREAM, WAIT and HOLD.
REQ-019 IDLE+start -> STREAM; STREAM lasts exactly 8 cycles (beat counter 0..7) -> WAIT; WAIT lasts RSLT_LAT cycles -> HOLD; HOLD+res_ack -> IDLE.
REQ-020 start outside IDLE SHALL be ignored, including start coincident with res_ack in HOLD.
REQ-021 fs_ready SHALL be high in STREAM only, registered, and low in every other state.
REQ-022 Beat k SHALL drive fs_cur_pix = cur row k.
REQ-023 Beats 0 and 1 SHALL drive fs_org_pix = 0; beat k (k = 2..7) SHALL drive fs_org_pix = org row (k-1)[55:8].
REQ-024 Outside STREAM, fs_cur_pix and fs_org_pix SHALL be 0.
REQ-025 On the last WAIT cycle the block SHALL capture fs_sad/fs_mvx/fs_mvy into res_* and set res_valid the next cycle.
REQ-026 res_* SHALL remain stable while res_valid is high.
REQ-027 At least 2 fs_ready-low cycles SHALL separate consecutive bursts; this is guaranteed by the WAIT and HOLD states.
REQ-028 A write with ld_valid && ld_ready SHALL update exactly one 64-bit row; writes with ld_ready low SHALL be dropped.
REQ-029 ld_ready SHALL be low in STREAM and WAIT, and high in IDLE and HOLD (single-bank build).
REQ-030 A write to the row being read in the same cycle is not possible in the single-bank build.

Reset
REQ-031 Asserting reset at any time SHALL force state IDLE, beat counter 0, fs_ready 0, fs_* data 0, res_valid 0, res_* 0, busy 0, ld_ready 1.
REQ-032 Row storage SHALL NOT be reset.
REQ-033 A reset during STREAM SHALL terminate the burst immediately, with no result produced.

Configuration
REQ-034 Macro FRAC_FEED_DBLBUF_EN, when defined, SHALL instantiate two storage banks.
REQ-035 With FRAC_FEED_DBLBUF_EN, writes always go to the shadow bank and ld_ready is constantly 1.
REQ-036 With FRAC_FEED_DBLBUF_EN, an accepted start SHALL swap banks, and STREAM SHALL read the bank made active by that start.
REQ-037 Without FRAC_FEED_DBLBUF_EN, there SHALL be a single bank with ld_ready per REQ-029.

Structure
REQ-038 Shared package frac_pkg SHALL hold PIX_W=8, BLK_ROWS=8, LINE_W=64, SAD_W=12, MV_W=3 and the state encoding.
REQ-039 Sub-module blk_buf (8x64 register file, one write port, one combinational read port) SHALL be instantiated per block per bank.

Verification
REQ-040 Load cur row r = {8{r}} and org row r = {8{8'h10+r}}, then pulse start -> fs_ready high exactly 8 cycles; beat 3 gives fs_cur_pix=64'h0303030303030303 and fs_org_pix=48'h121212121212; beats 0/1 give fs_org_pix=0.
REQ-041 Search model drives fs_sad=12'h123, fs_mvx=2, fs_mvy=3 on the cycle after the burst (RSLT_LAT=1) -> res_valid rises; values are held 5 cycles until res_ack; then IDLE.
REQ-042 start pulsed at beat 3 and in HOLD together with res_ack -> ignored; total fs_ready-high count is 8; a start on the next IDLE cycle launches a new burst.
REQ-043 Single-bank build: a write to cur row 2 = all-FF during STREAM is dropped, and the next burst shows the old row 2. DBLBUF build: the same write is accepted and appears on the next burst only.
REQ-044 reset asserted at beat 4 -> fs_ready=0 and busy=0 asynchronously with no res_valid; after release, reload plus start yields a correct full burst.

Source files
------------

// File: rtl/frac_pkg.sv
// Shared widths and FSM encoding for the fractional-search feeder.
// Every frac_feeder file imports this package.
package frac_pkg;

  localparam int PIX_W    = 8;
  localparam int BLK_ROWS = 8;
  localparam int LINE_W   = 64;
  localparam int SAD_W    = 12;
  localparam int MV_W     = 3;
  localparam int ROW_AW   = 3;
  localparam int ORG_W    = LINE_W - 2 * PIX_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/blk_buf.sv
// 8x64 block row store with one write port and one combinational read port.
// The contents are intentionally left unreset.
module blk_buf
  import frac_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ROW_AW-1:0] i_waddr,
  input  logic [LINE_W-1:0] i_wdata,
  input  logic [ROW_AW-1:0] i_raddr,
  output logic [LINE_W-1:0] o_rdata
);

  logic [LINE_W-1:0] r_mem [BLK_ROWS];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/frac_feeder.sv
// Streams a stored current/original block pair to the fractional search stage, then holds its result.
// Optional FRAC_FEED_DBLBUF_EN adds a shadow bank so rows can be loaded while a burst runs.
module frac_feeder
  import frac_pkg::*;
#(
  parameter int RSLT_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ld_valid,
  input  logic              i_ld_sel,
  input  logic [ROW_AW-1:0] i_ld_row,
  input  logic [LINE_W-1:0] i_ld_data,
  output logic              o_ld_ready,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_fs_ready,
  output logic [LINE_W-1:0] o_fs_cur_pix,
  output logic [ORG_W-1:0]  o_fs_org_pix,
  input  logic [SAD_W-1:0]  i_fs_sad,
  input  logic [MV_W-1:0]   i_fs_mvx,
  input  logic [MV_W-1:0]   i_fs_mvy,
  output logic              o_res_valid,
  output logic [SAD_W-1:0]  o_res_sad,
  output logic [MV_W-1:0]   o_res_mvx,
  output logic [MV_W-1:0]   o_res_mvy,
  input  logic              i_res_ack
);

  localparam logic [1:0] WAIT_LAST = 2'(RSLT_LAT - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [ROW_AW-1:0] r_beat;
  logic [ROW_AW-1:0] w_next_beat;
  logic [1:0]        r_wcnt;
  logic              w_start_acc;
  logic              w_capture;
  logic              w_stream_nx;
  logic              w_wr_acc;
  logic              w_wr_bank;
  logic [LINE_W-1:0] w_cur_rd;
  logic [LINE_W-1:0] w_org_rd;
  logic [ROW_AW-1:0] w_org_raddr;
  logic              r_fs_ready;
  logic [LINE_W-1:0] r_fs_cur;
  logic [ORG_W-1:0]  r_fs_org;
  logic              r_res_valid;
  logic [SAD_W-1:0]  r_res_sad;
  logic [MV_W-1:0]   r_res_mvx;
  logic [MV_W-1:0]   r_res_mvy;

`ifdef FRAC_FEED_DBLBUF_EN
  localparam int NBANK = 2;
  logic r_bank;
  logic w_rd_bank;
`else
  localparam int NBANK = 1;
`endif

  logic [LINE_W-1:0] w_cur_bank [NBANK];
  logic [LINE_W-1:0] w_org_bank [NBANK];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_next_state;
      r_beat  <= w_next_beat;
      r_wcnt  <= (r_state == ST_WAIT) ? r_wcnt + 2'd1 : 2'd0;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_beat  = r_beat;
    w_start_acc  = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next_state = ST_STREAM;
          w_next_beat  = '0;
          w_start_acc  = 1'b1;
        end
      end
      ST_STREAM: begin
        if (r_beat == 3'd7) begin
          w_next_state = ST_WAIT;
          w_next_beat  = '0;
        end else begin
          w_next_beat = r_beat + 3'd1;
        end
      end
      ST_WAIT: begin
        if (r_wcnt == WAIT_LAST) begin
          w_next_state = ST_HOLD;
          w_capture    = 1'b1;
        end
      end
      ST_HOLD: begin
        if (i_res_ack) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

`ifdef FRAC_FEED_DBLBUF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         r_bank <= 1'b0;
    else if (w_start_acc) r_bank <= ~r_bank;
  end

  // The read bank flips on the start cycle itself so beat 0 is prefetched from the new bank.
  assign w_rd_bank  = w_start_acc ? ~r_bank : r_bank;
  assign w_wr_bank  = ~r_bank;
  assign o_ld_ready = 1'b1;
  assign w_cur_rd   = w_rd_bank ? w_cur_bank[1] : w_cur_bank[0];
  assign w_org_rd   = w_rd_bank ? w_org_bank[1] : w_org_bank[0];
`else
  assign w_wr_bank  = 1'b0;
  assign o_ld_ready = (r_state == ST_IDLE) || (r_state == ST_HOLD);
  assign w_cur_rd   = w_cur_bank[0];
  assign w_org_rd   = w_org_bank[0];
`endif

  assign w_wr_acc    = i_ld_valid && o_ld_ready;
  assign w_org_raddr = w_next_beat - 3'd1;

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    blk_buf u_cur (
      .i_clk   (i_clk),
      .i_we    (w_wr_acc && !i_ld_sel && (w_wr_bank == 1'(b))),
      .i_waddr (i_ld_row),
      .i_wdata (i_ld_data),
      .i_raddr (w_next_beat),
      .o_rdata (w_cur_bank[b])
    );
    blk_buf u_org (
      .i_clk   (i_clk),
      .i_we    (w_wr_acc && i_ld_sel && (w_wr_bank == 1'(b))),
      .i_waddr (i_ld_row),
      .i_wdata (i_ld_data),
      .i_raddr (w_org_raddr),
      .o_rdata (w_org_bank[b])
    );
  end

  logic w_unused_org;
  assign w_unused_org = ^{w_org_rd[LINE_W-1:LINE_W-PIX_W], w_org_rd[PIX_W-1:0]};

  // Beat outputs are registered, so rows are fetched with the next-beat index.
  assign w_stream_nx = (w_next_state == ST_STREAM);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fs_ready  <= 1'b0;
      r_fs_cur    <= '0;
      r_fs_org    <= '0;
      r_res_valid <= 1'b0;
      r_res_sad   <= '0;
      r_res_mvx   <= '0;
      r_res_mvy   <= '0;
    end else begin
      r_fs_ready  <= w_stream_nx;
      r_fs_cur    <= w_stream_nx ? w_cur_rd : '0;
      r_fs_org    <= (w_stream_nx && (w_next_beat >= 3'd2)) ?
                     w_org_rd[LINE_W-PIX_W-1:PIX_W] : '0;
      r_res_valid <= (w_next_state == ST_HOLD);
      if (w_capture) begin
        r_res_sad <= i_fs_sad;
        r_res_mvx <= i_fs_mvx;
        r_res_mvy <= i_fs_mvy;
      end
    end
  end

  assign o_busy       = (r_state != ST_IDLE);
  assign o_fs_ready   = r_fs_ready;
  assign o_fs_cur_pix = r_fs_cur;
  assign o_fs_org_pix = r_fs_org;
  assign o_res_valid  = r_res_valid;
  assign o_res_sad    = r_res_sad;
  assign o_res_mvx    = r_res_mvx;
  assign o_res_mvy    = r_res_mvy;

endmodule

// File: tb/tb_frac_feeder.sv
// Directed scoreboard bench for frac_feeder in its default single-bank build.
// It models the block rows and the search stage, and checks beats and results against queued expectations.
module tb_frac_feeder;

  typedef struct packed {
    logic [63:0] cur;
    logic [47:0] org;
  } beat_t;

  typedef struct packed {
    logic [11:0] sad;
    logic [2:0]  mvx;
    logic [2:0]  mvy;
  } res_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        ldValid = 1'b0;
  logic        ldSel = 1'b0;
  logic [2:0]  ldRow = '0;
  logic [63:0] ldData = '0;
  logic        ldReady;
  logic        start = 1'b0;
  logic        busy;
  logic        fsReady;
  logic [63:0] fsCurPix;
  logic [47:0] fsOrgPix;
  logic [11:0] fsSad = '0;
  logic [2:0]  fsMvx = '0;
  logic [2:0]  fsMvy = '0;
  logic        resValid;
  logic [11:0] resSad;
  logic [2:0]  resMvx;
  logic [2:0]  resMvy;
  logic        resAck = 1'b0;

  int    nChecks = 0;
  int    nErrors = 0;
  int    beatCount = 0;
  int    lowRun = 0;
  bit    seenBurst = 1'b0;
  bit    prevMon = 1'b0;
  bit    prevSearch = 1'b0;
  res_t  searchRes = '0;
  res_t  expRes;
  beat_t expQ[$];
  res_t  resQ[$];
  logic [63:0] curModel [8];
  logic [63:0] orgModel [8];

  frac_feeder #(.RSLT_LAT(1)) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_ld_valid   (ldValid),
    .i_ld_sel     (ldSel),
    .i_ld_row     (ldRow),
    .i_ld_data    (ldData),
    .o_ld_ready   (ldReady),
    .i_start      (start),
    .o_busy       (busy),
    .o_fs_ready   (fsReady),
    .o_fs_cur_pix (fsCurPix),
    .o_fs_org_pix (fsOrgPix),
    .i_fs_sad     (fsSad),
    .i_fs_mvx     (fsMvx),
    .i_fs_mvy     (fsMvy),
    .o_res_valid  (resValid),
    .o_res_sad    (resSad),
    .o_res_mvx    (resMvx),
    .o_res_mvy    (resMvy),
    .i_res_ack    (resAck)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one cycle of inputs just after a rising edge, then returns all strobes low.
  task automatic applyStimulus(input logic v, input logic sel, input logic [2:0] row,
                               input logic [63:0] data, input logic st, input logic ack);
    ldValid = v; ldSel = sel; ldRow = row; ldData = data; start = st; resAck = ack;
    @(posedge clk);
    #1;
    ldValid = 1'b0; start = 1'b0; resAck = 1'b0;
  endtask

  task automatic loadBlock(input logic [7:0] curBase, input logic [7:0] orgBase);
    for (int r = 0; r < 8; r++) begin
      curModel[r] = {8{curBase + 8'(r)}};
      orgModel[r] = {8{orgBase + 8'(r)}};
      applyStimulus(1'b1, 1'b0, 3'(r), curModel[r], 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 3'(r), orgModel[r], 1'b0, 1'b0);
    end
  endtask

  task automatic pushBurst(input logic [11:0] sad, input logic [2:0] mvx, input logic [2:0] mvy);
    beat_t b;
    for (int k = 0; k < 8; k++) begin
      b.cur = curModel[k];
      b.org = (k < 2) ? 48'h0 : orgModel[k-1][55:8];
      expQ.push_back(b);
    end
    searchRes = '{sad: sad, mvx: mvx, mvy: mvy};
    resQ.push_back(searchRes);
  endtask

  task automatic waitResult(input string tag);
    int waited = 0;
    while (!resValid && waited < 20) begin
      waitCycles(1);
      waited++;
    end
    checkOutput({tag, "_valid"}, 64'(resValid), 64'd1);
    if (resValid && resQ.size() != 0) begin
      expRes = resQ.pop_front();
      checkOutput({tag, "_sad"}, 64'(resSad), 64'(expRes.sad));
      checkOutput({tag, "_mvx"}, 64'(resMvx), 64'(expRes.mvx));
      checkOutput({tag, "_mvy"}, 64'(resMvy), 64'(expRes.mvy));
    end
  endtask

  // Beat scoreboard and idle-zero checks, sampled on the falling edge.
  always @(negedge clk) begin
    if (fsReady) begin
      beatCount++;
      if (!prevMon && seenBurst) checkOutput("burst_gap", 64'(lowRun >= 2), 64'd1);
      seenBurst = 1'b1;
      lowRun = 0;
      checkOutput("beat_pending", 64'(expQ.size() != 0), 64'd1);
      if (expQ.size() != 0) begin
        beat_t e;
        e = expQ.pop_front();
        checkOutput("beat_cur", fsCurPix, e.cur);
        checkOutput("beat_org", 64'(fsOrgPix), 64'(e.org));
      end
    end else begin
      lowRun++;
      checkOutput("idle_cur", fsCurPix, 64'h0);
      checkOutput("idle_org", 64'(fsOrgPix), 64'h0);
    end
    prevMon = fsReady;
  end

  // Search stage: presents the result only in the cycle right after a burst ends.
  always @(negedge clk) begin
    if (prevSearch && !fsReady) begin
      fsSad = searchRes.sad; fsMvx = searchRes.mvx; fsMvy = searchRes.mvy;
    end else begin
      fsSad = '0; fsMvx = '0; fsMvy = '0;
    end
    prevSearch = fsReady;
  end

  initial begin
    int beatsBefore;
    #3;
    checkOutput("rst_fs_ready", 64'(fsReady), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_ld_ready", 64'(ldReady), 64'd1);
    checkOutput("rst_res_valid", 64'(resValid), 64'd0);
    checkOutput("rst_res_sad", 64'(resSad), 64'd0);
    waitCycles(2);
    rstN = 1'b1;
    waitCycles(1);

    loadBlock(8'h00, 8'h10);
    checkOutput("idle_ld_ready", 64'(ldReady), 64'd1);

    // Burst 1, with an ignored start and a dropped write at beat 3.
    beatsBefore = beatCount;
    pushBurst(12'h123, 3'd2, 3'd3);
    applyStimulus(1'b0, 1'b0, 3'd0, 64'h0, 1'b1, 1'b0);
    checkOutput("b1_busy", 64'(busy), 64'd1);
    waitCycles(3);
    checkOutput("b1_beat3_cur", fsCurPix, 64'h0303030303030303);
    checkOutput("b1_beat3_org", 64'(fsOrgPix), 64'h121212121212);
    checkOutput("stream_ld_ready", 64'(ldReady), 64'd0);
    applyStimulus(1'b1, 1'b0, 3'd2, {64{1'b1}}, 1'b1, 1'b0);
    waitResult("b1_res");
    for (int i = 0; i < 5; i++) begin
      waitCycles(1);
      checkOutput("hold_valid", 64'(resValid), 64'd1);
      checkOutput("hold_sad", 64'(resSad), 64'h123);
      checkOutput("hold_mv", 64'({resMvx, resMvy}), 64'({3'd2, 3'd3}));
    end
    checkOutput("hold_ld_ready", 64'(ldReady), 64'd1);
    applyStimulus(1'b0, 1'b0, 3'd0, 64'h0, 1'b1, 1'b1);
    checkOutput("ack_res_valid", 64'(resValid), 64'd0);
    checkOutput("ack_busy", 64'(busy), 64'd0);
    waitCycles(2);
    checkOutput("ignored_start_busy", 64'(busy), 64'd0);
    checkOutput("b1_beat_total", 64'(beatCount - beatsBefore), 64'd8);

    // Burst 2 must still show the original row 2.
    beatsBefore = beatCount;
    pushBurst(12'h7ff, 3'd5, 3'd1);
    applyStimulus(1'b0, 1'b0, 3'd0, 64'h0, 1'b1, 1'b0);
    waitResult("b2_res");
    checkOutput("b2_beat_total", 64'(beatCount - beatsBefore), 64'd8);
    applyStimulus(1'b0, 1'b0, 3'd0, 64'h0, 1'b0, 1'b1);
    waitCycles(1);

    // Burst 3 aborted by reset at beat 4.
    pushBurst(12'h0aa, 3'd7, 3'd6);
    applyStimulus(1'b0, 1'b0, 3'd0, 64'h0, 1'b1, 1'b0);
    waitCycles(4);
    rstN = 1'b0;
    #1;
    checkOutput("abort_fs_ready", 64'(fsReady), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_ld_ready", 64'(ldReady), 64'd1);
    expQ.delete();
    void'(resQ.pop_back());
    waitCycles(2);
    rstN = 1'b1;
    waitCycles(12);
    checkOutput("abort_res_valid", 64'(resValid), 64'd0);
    checkOutput("abort_idle_busy", 64'(busy), 64'd0);

    // Burst 4 after reloading fresh rows.
    loadBlock(8'h40, 8'h60);
    beatsBefore = beatCount;
    pushBurst(12'h5a5, 3'd4, 3'd0);
    applyStimulus(1'b0, 1'b0, 3'd0, 64'h0, 1'b1, 1'b0);
    waitResult("b4_res");
    checkOutput("b4_beat_total", 64'(beatCount - beatsBefore), 64'd8);
    applyStimulus(1'b0, 1'b0, 3'd0, 64'h0, 1'b0, 1'b1);
    waitCycles(2);
    checkOutput("end_busy", 64'(busy), 64'd0);
    checkOutput("beats_left", 64'(expQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
